argmax_classifier: RTL and testbench

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

---
 rtl/argmax_classifier.sv | 125 ++++++++++++
 tb/tb_argmax_classifier.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/argmax_classifier.sv
// Streaming argmax over NUM_CLASSES signed scores: reports the winning class,
// its score and the (never-overflowing) margin over the runner-up.
module argmax_classifier #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [3:0]        predicted_class,
    output logic [DATA_W-1:0] max_score,
    output logic [DATA_W:0]   margin,
    output logic              done,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_t;

    localparam logic signed [DATA_W-1:0] MIN_SCORE = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [3:0]               LAST_IDX  = 4'(NUM_CLASSES - 1);

    state_t state, state_nxt;

    logic [3:0]               cnt;
    logic signed [DATA_W-1:0] best, second;
    logic [3:0]               best_idx;

    logic signed [DATA_W-1:0] score;
    logic signed [DATA_W-1:0] nxt_best, nxt_second;
    logic [3:0]               nxt_idx;
    logic [DATA_W:0]          nxt_margin;
    logic                     accept, last_beat;

    assign score     = in_data;
    assign accept    = (state == S_COLLECT) && in_valid;
    assign last_beat = accept && (cnt == LAST_IDX);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start)     state_nxt = S_COLLECT;
            S_COLLECT: if (last_beat) state_nxt = S_DONE;
            S_DONE:                   state_nxt = S_IDLE;
            default:                  state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        busy     = 1'b0;
        case (state)
            S_COLLECT: begin in_ready = 1'b1; busy = 1'b1; end
            S_DONE:    begin done     = 1'b1; busy = 1'b1; end
            default:   ;
        endcase
    end

    // Candidate tracker update for the beat on in_data; strict compare keeps
    // the lowest index on ties while an equal score still lands in second.
    always_comb begin
        nxt_best   = best;
        nxt_second = second;
        nxt_idx    = best_idx;
        if (cnt == 4'd0) begin
            nxt_best   = score;
            nxt_second = MIN_SCORE;
            nxt_idx    = 4'd0;
        end else if (score > best) begin
            nxt_second = best;
            nxt_best   = score;
            nxt_idx    = cnt;
        end else if (score > second) begin
            nxt_second = score;
        end
    end

    // best >= second always, so the widened difference is non-negative.
    assign nxt_margin = {nxt_best[DATA_W-1], nxt_best} - {nxt_second[DATA_W-1], nxt_second};

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt             <= '0;
            best            <= MIN_SCORE;
            second          <= MIN_SCORE;
            best_idx        <= '0;
            predicted_class <= '0;
            max_score       <= '0;
            margin          <= '0;
        end else if (state == S_IDLE && start) begin
            cnt      <= '0;
            best     <= MIN_SCORE;
            second   <= MIN_SCORE;
            best_idx <= '0;
        end else if (accept) begin
            cnt      <= cnt + 4'd1;
            best     <= nxt_best;
            second   <= nxt_second;
            best_idx <= nxt_idx;
            // Results are captured from the final beat so they are valid in DONE.
            if (last_beat) begin
                predicted_class <= nxt_idx;
                max_score       <= nxt_best;
                margin          <= nxt_margin;
            end
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: hand-computed vectors, latency,
// stall, reset-abort and spurious start/in_valid scenarios.
module tb_argmax_classifier;

    logic               clk = 1'b0;
    logic               rst, start, in_valid;
    logic [15:0]        in_data;
    logic               in_ready, done, busy;
    logic [3:0]         predicted_class;
    logic signed [15:0] max_score;
    logic [16:0]        margin;

    int cmp  = 0;
    int errs = 0;
    int acc_cnt  = 0;
    int done_cnt = 0;

    argmax_classifier #(.NUM_CLASSES(10), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .predicted_class(predicted_class), .max_score(max_score),
        .margin(margin), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Beats that will be taken at the coming rising edge, and done pulses.
    always @(negedge clk) begin
        if (rst && in_valid && in_ready) acc_cnt++;
        if (done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // lat counts cycles inclusively, from the cycle start is high to the done cycle.
    task automatic classify(input logic signed [15:0] s [10], input bit gap, input bit noise,
                            output int lat);
        int k = 0;
        int cyc = 1;
        start = 1'b1;
        if (noise) begin in_valid = 1'b1; in_data = 16'd1000; end
        step();
        start = 1'b0;
        in_valid = 1'b0;
        cyc = 2;
        while (done !== 1'b1 && cyc < 60) begin
            start = (noise && cyc == 5);
            if (k < 10 && (!gap || cyc % 2 == 0)) begin
                in_valid = 1'b1;
                in_data  = s[k];
                k++;
            end else begin
                in_valid = 1'b0;
            end
            step();
            cyc++;
        end
        lat = cyc;
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        logic signed [15:0] v_a   [10] = '{16'sd5, -16'sd3, 16'sd12, 16'sd7, 16'sd0,
                                           16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd6};
        logic signed [15:0] v_eq  [10] = '{default: -16'sd100};
        logic signed [15:0] v_ext [10] = '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000,
                                           16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sd32767};
        logic signed [15:0] v_inc [10] = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5,
                                           16'sd6, 16'sd7, 16'sd8, 16'sd9, 16'sd10};
        int lat, a0, d0;

        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        step(); step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_class", predicted_class, 0);
        chk("rst_max", max_score, 0);
        chk("rst_margin", margin, 0);
        rst = 1'b1;
        step();

        // Basic vector, continuous in_valid
        a0 = acc_cnt; d0 = done_cnt;
        classify(v_a, 1'b0, 1'b0, lat);
        chk("a_latency", lat, 12);
        chk("a_done", done, 1);
        chk("a_busy_done", busy, 1);
        chk("a_class", predicted_class, 2);
        chk("a_max", max_score, 12);
        chk("a_margin", margin, 5);
        step();
        chk("a_done_drop", done, 0);
        chk("a_busy_idle", busy, 0);
        chk("a_ready_idle", in_ready, 0);
        step(); step();
        chk("a_hold_class", predicted_class, 2);
        chk("a_hold_margin", margin, 5);
        chk("a_beats", acc_cnt - a0, 10);
        chk("a_done_pulses", done_cnt - d0, 1);

        // All equal: tie goes to class 0, margin 0
        classify(v_eq, 1'b0, 1'b0, lat);
        chk("eq_class", predicted_class, 0);
        chk("eq_max", max_score, -100);
        chk("eq_margin", margin, 0);
        step();

        // Extremes: full-range margin
        classify(v_ext, 1'b0, 1'b0, lat);
        chk("ext_class", predicted_class, 9);
        chk("ext_max", max_score, 32767);
        chk("ext_margin", margin, 65535);
        step();

        // in_valid low every other cycle
        a0 = acc_cnt;
        classify(v_a, 1'b1, 1'b0, lat);
        chk("gap_latency", lat, 21);
        chk("gap_class", predicted_class, 2);
        chk("gap_max", max_score, 12);
        chk("gap_margin", margin, 5);
        step();
        chk("gap_beats", acc_cnt - a0, 10);

        // Reset after 4 beats, then a fresh run
        d0 = done_cnt;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 16'(500 + i);
            step();
        end
        in_valid = 1'b0;
        rst = 1'b0;
        step();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_class", predicted_class, 0);
        chk("mid_rst_max", max_score, 0);
        chk("mid_rst_margin", margin, 0);
        rst = 1'b1;
        step(); step(); step();
        chk("mid_rst_no_done", done_cnt - d0, 0);
        classify(v_inc, 1'b0, 1'b0, lat);
        chk("inc_class", predicted_class, 9);
        chk("inc_max", max_score, 10);
        chk("inc_margin", margin, 1);
        step();
        chk("inc_done_pulses", done_cnt - d0, 1);

        // Spurious in_valid in IDLE and start during COLLECT
        a0 = acc_cnt; d0 = done_cnt;
        in_valid = 1'b1; in_data = 16'd2000;
        step(); step();
        in_valid = 1'b0;
        chk("noise_idle_busy", busy, 0);
        classify(v_a, 1'b0, 1'b1, lat);
        chk("noise_latency", lat, 12);
        chk("noise_class", predicted_class, 2);
        chk("noise_max", max_score, 12);
        chk("noise_margin", margin, 5);
        step(); step();
        chk("noise_beats", acc_cnt - a0, 10);
        chk("noise_done_pulses", done_cnt - d0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
